draw_sequencer: RTL and testbench
=================================

Name: draw_sequencer

Overview:
- Sequences up to NCLIENTS drawing engines (fillscreen, circle, reuleaux) one after another through the lab start/done handshake.
- Shares the single vga_adapter plot port between them: muxes the active engine's x/y/colour/plot and clips off-screen pixels.
- Sits between the task-level top (KEY/SW) and the vga_adapter instance.

Parameters:
- NCLIENTS, 2, number of drawing engines attached (1..8); client 0 runs first.
- SCREEN_W, 160, horizontal pixel count; plots with x >= SCREEN_W are dropped.
- SCREEN_H, 120, vertical pixel count; plots with y >= SCREEN_H are dropped.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level request; held high for the whole job.
- en_mask  in  NCLIENTS  client enable bits, sampled when start is accepted; 0 = skip that client.
- done  out  1  high while the job is complete and start is still high.
- busy  out  1  high in every state except IDLE and FINISH.
- active_idx  out  3  index of the client currently owning the plot port.
- cl_start  out  NCLIENTS  per-client start; at most one bit high at any time.
- cl_done  in  NCLIENTS  per-client done.
- cl_x  in  8*NCLIENTS  client x; client i occupies bits [8i+7:8i].
- cl_y  in  7*NCLIENTS  client y; client i occupies bits [7i+6:7i].
- cl_colour  in  3*NCLIENTS  client colour; client i occupies bits [3i+2:3i].
- cl_plot  in  NCLIENTS  per-client plot strobe.
- vga_x  out  8  to vga_adapter.
- vga_y  out  7  to vga_adapter.
- vga_colour  out  3  to vga_adapter.
- vga_plot  out  1  to vga_adapter.
- plot_count  out  15  pixels passed to the adapter during the current job (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state IDLE; idx=0; en_q=0.
  - All outputs 0: cl_start, done, busy, active_idx, vga_*, plot_count.
- States: IDLE, SEEK, RUN, RELEASE, FINISH, DRAIN.
- IDLE:
  - start=1 -> latch en_q<=en_mask, idx<=0, go to SEEK.
- SEEK (one cycle):
  - If any en_q bit at position >= idx is set: idx <= lowest such index, go to RUN.
  - Otherwise go to FINISH.
- RUN:
  - cl_start[idx] is registered high, first asserted on the cycle after SEEK.
  - cl_done[idx]=1 -> go to RELEASE.
- RELEASE:
  - cl_start all 0.
  - Stay until cl_done[idx]=0, then idx <= idx+1 and go to SEEK.
  - If idx was NCLIENTS-1, go directly to FINISH.
- FINISH:
  - done=1.
  - start=0 -> next cycle done=0, go to IDLE.
- Abort: start=0 while in SEEK, RUN or RELEASE -> go to DRAIN.
  - DRAIN: cl_start all 0; wait for cl_done[idx]=0; then go to IDLE.
  - done is never asserted on an aborted job.
- Plot path (registered, 1-cycle latency):
  - vga_x, vga_y, vga_colour <= client[idx] fields every cycle.
  - vga_plot <= (state==RUN) & cl_plot[idx] & (cl_x[idx] < SCREEN_W) & (cl_y[idx] < SCREEN_H).
  - Plots from non-active clients are ignored.
  - Plots during RELEASE, DRAIN or FINISH are ignored.
- active_idx = idx, zero-extended to 3 bits.
- Boundaries:
  - en_mask all 0 -> done=1 two cycles after start is accepted.
  - Client with cl_done already high on entry to RUN -> RELEASE on the next cycle.
  - en_mask changes during a job -> no effect.
  - start re-asserted in the same cycle FINISH returns to IDLE -> accepted in IDLE on the following cycle.

Optional Feature:
- Macro: DRAW_SEQ_PLOT_COUNT_EN.
- Defined:
  - plot_count increments on each cycle vga_plot=1, saturating at 32767.
  - Cleared to 0 on IDLE->SEEK.
  - Holds its value in FINISH and IDLE.
- Undefined: plot_count tied to 0; no counter logic.

Decomposition:
- Package draw_pkg:
  - SCREEN_W, SCREEN_H.
  - X_W=8, Y_W=7, COL_W=3.
  - seq_state_t enum {IDLE, SEEK, RUN, RELEASE, FINISH, DRAIN}.
- Sub-module plot_clip: registered mux of the active client plus the bounds check.
  - Inputs: idx, run flag, client buses.
  - Outputs: vga_x, vga_y, vga_colour, vga_plot.

Test Plan:
- NCLIENTS=2, en_mask=2'b11, behavioural clients; client 0 plots 19200 pixels, client 1 plots 50 -> cl_start[1] never high before cl_done[0] falls; done=1 with plot_count=19250.
- Client 1 drives x=160,y=5 then x=159,y=119 with plot=1 -> first dropped (vga_plot=0), second appears on vga_* exactly one cycle later.
- en_mask=2'b10 -> cl_start[0] stays 0 for the whole job; active_idx=1 while in RUN.
- en_mask=2'b00, start=1 at cycle 0 -> done=1 at cycle 2; busy high only during SEEK.
- start dropped mid-run of client 0 -> cl_start=0 next cycle; done stays 0; IDLE after cl_done[0] falls; a new start restarts from client 0 with plot_count=0.
- rst pulsed while in RUN, asynchronous to clk -> all outputs 0 immediately, before the next clk edge; state IDLE.

Source files
------------

// File: rtl/draw_pkg.sv
// draw_pkg: screen geometry, client bus widths and sequencer state encoding
// shared by draw_sequencer and plot_clip.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;
    localparam int IDX_W = 3;
    localparam int CNT_W = 15;

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        RUN,
        RELEASE,
        FINISH,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/plot_clip.sv
// plot_clip: registered mux of the active client's plot fields onto the
// single vga_adapter port, dropping plots that fall outside the screen.
module plot_clip
    import draw_pkg::*;
#(
    parameter int NCLIENTS = 2,
    parameter int SCREEN_W = draw_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic                      i_run,
    input  logic [NCLIENTS*X_W-1:0]   i_cl_x,
    input  logic [NCLIENTS*Y_W-1:0]   i_cl_y,
    input  logic [NCLIENTS*COL_W-1:0] i_cl_colour,
    input  logic [NCLIENTS-1:0]       i_cl_plot,
    output logic [X_W-1:0]            o_vga_x,
    output logic [Y_W-1:0]            o_vga_y,
    output logic [COL_W-1:0]          o_vga_colour,
    output logic                      o_vga_plot
);

    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic [COL_W-1:0] w_col;
    logic             w_plot;
    logic             w_inb;

    assign w_x    = X_W'(i_cl_x >> (X_W * int'(i_idx)));
    assign w_y    = Y_W'(i_cl_y >> (Y_W * int'(i_idx)));
    assign w_col  = COL_W'(i_cl_colour >> (COL_W * int'(i_idx)));
    assign w_plot = 1'(i_cl_plot >> i_idx);
    assign w_inb  = (32'(w_x) < 32'(SCREEN_W)) &&
                    (32'(w_y) < 32'(SCREEN_H));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vga_x      <= '0;
            o_vga_y      <= '0;
            o_vga_colour <= '0;
            o_vga_plot   <= 1'b0;
        end else begin
            o_vga_x      <= w_x;
            o_vga_y      <= w_y;
            o_vga_colour <= w_col;
            o_vga_plot   <= i_run & w_plot & w_inb;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: runs enabled drawing engines in index order and shares the
// vga plot port between them. DRAW_SEQ_PLOT_COUNT_EN adds a plot counter.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int NCLIENTS = 2,
    parameter int SCREEN_W = draw_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NCLIENTS-1:0]       en_mask,
    output logic                      done,
    output logic                      busy,
    output logic [IDX_W-1:0]          active_idx,
    output logic [NCLIENTS-1:0]       cl_start,
    input  logic [NCLIENTS-1:0]       cl_done,
    input  logic [NCLIENTS*X_W-1:0]   cl_x,
    input  logic [NCLIENTS*Y_W-1:0]   cl_y,
    input  logic [NCLIENTS*COL_W-1:0] cl_colour,
    input  logic [NCLIENTS-1:0]       cl_plot,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [COL_W-1:0]          vga_colour,
    output logic                      vga_plot,
    output logic [CNT_W-1:0]          plot_count
);

    localparam logic [IDX_W-1:0]    LAST = IDX_W'(NCLIENTS - 1);
    localparam logic [NCLIENTS-1:0] ONE  = NCLIENTS'(1);

    seq_state_t          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [NCLIENTS-1:0] r_en_q;
    logic [NCLIENTS-1:0] r_cl_start;

    logic                w_cur_done;
    logic                w_found;
    logic [IDX_W-1:0]    w_next;

    assign w_cur_done = 1'(cl_done >> r_idx);

    // Lowest enabled client at or above the current index.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        for (int i = NCLIENTS - 1; i >= 0; i--) begin
            if (r_en_q[i] && (IDX_W'(i) >= r_idx)) begin
                w_found = 1'b1;
                w_next  = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_en_q     <= '0;
            r_cl_start <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_en_q  <= en_mask;
                        r_idx   <= '0;
                        r_state <= SEEK;
                    end
                end
                SEEK: begin
                    if (!start) begin
                        r_state <= DRAIN;
                    end else if (w_found) begin
                        r_idx      <= w_next;
                        r_cl_start <= ONE << w_next;
                        r_state    <= RUN;
                    end else begin
                        r_state <= FINISH;
                    end
                end
                RUN: begin
                    if (!start) begin
                        r_cl_start <= '0;
                        r_state    <= DRAIN;
                    end else if (w_cur_done) begin
                        r_cl_start <= '0;
                        r_state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!start) begin
                        r_state <= DRAIN;
                    end else if (!w_cur_done) begin
                        if (r_idx == LAST) begin
                            r_state <= FINISH;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= SEEK;
                        end
                    end
                end
                FINISH: begin
                    if (!start) r_state <= IDLE;
                end
                DRAIN: begin
                    if (!w_cur_done) r_state <= IDLE;
                end
                default: begin
                    r_cl_start <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign cl_start   = r_cl_start;
    assign active_idx = r_idx;
    assign done       = (r_state == FINISH);
    assign busy       = (r_state != IDLE) && (r_state != FINISH);

    plot_clip #(
        .NCLIENTS (NCLIENTS),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .clk          (clk),
        .rst          (rst),
        .i_idx        (r_idx),
        .i_run        (r_state == RUN),
        .i_cl_x       (cl_x),
        .i_cl_y       (cl_y),
        .i_cl_colour  (cl_colour),
        .i_cl_plot    (cl_plot),
        .o_vga_x      (vga_x),
        .o_vga_y      (vga_y),
        .o_vga_colour (vga_colour),
        .o_vga_plot   (vga_plot)
    );

`ifdef DRAW_SEQ_PLOT_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    // vga_plot is already low in IDLE and FINISH, so the count holds there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_cnt <= '0;
        end else if (vga_plot && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign plot_count = r_cnt;
`else
    assign plot_count = '0;
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: randomized clients against a transaction-level
// reference of the sequencer, plus directed boundary jobs.
module tb_draw_sequencer;

    localparam int N = 2;

`ifdef DRAW_SEQ_PLOT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef enum int {M_IDLE, M_SEEK, M_RUN, M_REL, M_FIN, M_DRAIN} mph_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  en_mask;
    logic          done;
    logic          busy;
    logic [2:0]    active_idx;
    logic [N-1:0]  cl_start;
    logic [N-1:0]  cl_done;
    logic [8*N-1:0] cl_x;
    logic [7*N-1:0] cl_y;
    logic [3*N-1:0] cl_colour;
    logic [N-1:0]  cl_plot;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic [14:0]   plot_count;

    always #5 clk = ~clk;

    draw_sequencer #(.NCLIENTS(N), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .en_mask    (en_mask),
        .done       (done),
        .busy       (busy),
        .active_idx (active_idx),
        .cl_start   (cl_start),
        .cl_done    (cl_done),
        .cl_x       (cl_x),
        .cl_y       (cl_y),
        .cl_colour  (cl_colour),
        .cl_plot    (cl_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .plot_count (plot_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model
    mph_t       m_ph;
    int         m_idx;
    int         m_cnt;
    int         pend[$];
    logic [N-1:0] e_cl_start;
    logic       e_busy, e_done, e_vp;
    logic [2:0] e_idx;
    logic [7:0] e_vx;
    logic [6:0] e_vy;
    logic [2:0] e_vc;

    // bench clients and job control
    int   c_st[N], c_left[N], c_dly[N], c_len[N];
    bit   c_pre[N];
    bit   fill0, wide;
    int   fill_k;
    int   dq_x[$], dq_y[$];
    logic req_start;
    logic [N-1:0] job_mask;
    int   cyc = 0;
    int   t_acc = 0;

    task automatic model_reset();
        m_ph = M_IDLE; m_idx = 0; m_cnt = 0;
        pend.delete();
        e_cl_start = '0; e_busy = 0; e_done = 0; e_vp = 0;
        e_idx = 0; e_vx = 0; e_vy = 0; e_vc = 0;
    endtask

    task automatic model_adv();
        int cx, cy;
        logic d, np;
        cx = int'(cl_x[8*m_idx +: 8]);
        cy = int'(cl_y[7*m_idx +: 7]);
        e_vx = 8'(cx);
        e_vy = 7'(cy);
        e_vc = cl_colour[3*m_idx +: 3];
        np = (m_ph == M_RUN) && cl_plot[m_idx] && cx < 160 && cy < 120;
        if (m_ph == M_IDLE && start) m_cnt = 0;
        else if (e_vp && m_cnt < 32767) m_cnt++;
        e_vp = np;
        d = cl_done[m_idx];
        case (m_ph)
            M_IDLE: if (start) begin
                pend.delete();
                for (int i = 0; i < N; i++) if (en_mask[i]) pend.push_back(i);
                m_idx = 0; m_ph = M_SEEK;
            end
            M_SEEK: begin
                if (!start) m_ph = M_DRAIN;
                else if (pend.size() == 0) m_ph = M_FIN;
                else begin m_idx = pend.pop_front(); m_ph = M_RUN; end
            end
            M_RUN: begin
                if (!start) m_ph = M_DRAIN;
                else if (d) m_ph = M_REL;
            end
            M_REL: begin
                if (!start) m_ph = M_DRAIN;
                else if (!d) begin
                    if (m_idx == N - 1) m_ph = M_FIN;
                    else begin m_idx++; m_ph = M_SEEK; end
                end
            end
            M_FIN: if (!start) m_ph = M_IDLE;
            default: if (!d) m_ph = M_IDLE;
        endcase
        e_cl_start = (m_ph == M_RUN) ? N'(1 << m_idx) : '0;
        e_busy = !(m_ph == M_IDLE || m_ph == M_FIN);
        e_done = (m_ph == M_FIN);
        e_idx = 3'(m_idx);
    endtask

    task automatic pixel(input int i);
        int x, y;
        if (i == 0 && fill0) begin
            x = fill_k % 160; y = fill_k / 160; fill_k++;
        end else if (i == 1 && dq_x.size() > 0) begin
            x = dq_x.pop_front(); y = dq_y.pop_front();
        end else if (wide) begin
            x = $urandom_range(0, 175); y = $urandom_range(0, 127);
        end else begin
            x = $urandom_range(0, 159); y = $urandom_range(0, 119);
        end
        cl_x[8*i +: 8] = 8'(x);
        cl_y[7*i +: 7] = 7'(y);
    endtask

    task automatic client_update(input int i);
        logic s;
        s = cl_start[i];
        cl_x[8*i +: 8] = 8'($urandom);
        cl_y[7*i +: 7] = 7'($urandom);
        cl_colour[3*i +: 3] = 3'($urandom);
        cl_plot[i] = 1'b0;
        case (c_st[i])
            0: begin
                cl_done[i] = c_pre[i];
                if (s) begin
                    c_st[i] = c_pre[i] ? 2 : 1;
                    c_left[i] = c_len[i];
                end
            end
            1: begin
                if (!s || c_left[i] == 0) begin
                    cl_done[i] = 1'b1; c_st[i] = 2;
                end else begin
                    cl_plot[i] = 1'b1; pixel(i); c_left[i]--;
                end
            end
            2: begin
                cl_done[i] = 1'b1;
                if (!s) begin
                    c_pre[i] = 0; c_dly[i] = $urandom_range(0, 2); c_st[i] = 3;
                end
            end
            default: begin
                if (c_dly[i] == 0) begin cl_done[i] = 1'b0; c_st[i] = 0; end
                else c_dly[i]--;
            end
        endcase
    endtask

    task automatic reset_clients();
        for (int i = 0; i < N; i++) begin
            c_st[i] = 0; c_pre[i] = 0; c_left[i] = 0; c_dly[i] = 0;
        end
        cl_done = '0; cl_plot = '0; cl_x = '0; cl_y = '0; cl_colour = '0;
    endtask

    task automatic cmp_all();
        check("cl_start", cl_start, e_cl_start);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("active_idx", active_idx, e_idx);
        check("vga_x", vga_x, e_vx);
        check("vga_y", vga_y, e_vy);
        check("vga_colour", vga_colour, e_vc);
        check("vga_plot", vga_plot, e_vp);
        check("plot_count", plot_count, CNT_EN ? m_cnt : 0);
    endtask

    task automatic drive_adv();
        for (int i = 0; i < N; i++) client_update(i);
        start = req_start;
        en_mask = (m_ph == M_IDLE) ? job_mask : N'($urandom);
        if (m_ph == M_IDLE && start) t_acc = cyc;
        model_adv();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        cmp_all();
        drive_adv();
    endtask

    task automatic check_zero(input string p);
        check({p, "_cl_start"}, cl_start, 0);
        check({p, "_done"}, done, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_idx"}, active_idx, 0);
        check({p, "_vga_x"}, vga_x, 0);
        check({p, "_vga_y"}, vga_y, 0);
        check({p, "_vga_col"}, vga_colour, 0);
        check({p, "_vga_plot"}, vga_plot, 0);
        check({p, "_count"}, plot_count, 0);
    endtask

    task automatic run_job(input logic [N-1:0] mask, input int abort_at,
                           input int exp_cnt, output bit seen_done,
                           output int nplot, output bit st0_hi,
                           output int lat);
        bit fin;
        int hold;
        job_mask = mask; req_start = 1'b1;
        seen_done = 0; nplot = 0; st0_hi = 0; lat = -1; fin = 0; hold = 0;
        for (int c = 0; c < 30000 && !fin; c++) begin
            step();
            if (cl_start[0]) st0_hi = 1;
            if (vga_plot) nplot++;
            if (abort_at >= 0 && c == abort_at) req_start = 1'b0;
            if (done && !seen_done) begin
                seen_done = 1;
                lat = cyc - t_acc;
                if (exp_cnt >= 0)
                    check("job_plot_count", plot_count, CNT_EN ? exp_cnt : 0);
                hold = $urandom_range(0, 2);
            end else if (seen_done) begin
                if (hold == 0) req_start = 1'b0;
                else hold--;
            end
            if (!req_start && m_ph == M_IDLE) fin = 1;
        end
        if (!fin) check("job_timeout", 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit sd, s0;
        int np, lat;
        rst = 1'b1; start = 1'b0; en_mask = '0;
        req_start = 1'b0; job_mask = '0;
        fill0 = 0; wide = 0; fill_k = 0;
        c_len[0] = 0; c_len[1] = 0;
        reset_clients();
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        drive_adv();

        // long fill on client 0 then a short client 1
        fill0 = 1; fill_k = 0; wide = 0;
        c_len[0] = 19200; c_len[1] = 50;
        run_job(2'b11, -1, 19250, sd, np, s0, lat);
        check("job1_done", sd, 1);
        fill0 = 0;

        // clip boundary on client 1 alone
        dq_x = {160, 159}; dq_y = {5, 119};
        c_len[1] = 2;
        run_job(2'b10, -1, 1, sd, np, s0, lat);
        check("clip_plots", np, 1);
        check("clip_cl_start0", s0, 0);

        // nothing enabled
        run_job(2'b00, -1, 0, sd, np, s0, lat);
        check("empty_latency", lat, 2);

        // abort mid-run of client 0, then restart
        wide = 1; c_len[0] = 40; c_len[1] = 10;
        run_job(2'b11, 10, -1, sd, np, s0, lat);
        check("abort_done", sd, 0);
        c_len[0] = 5; c_len[1] = 7; c_pre[1] = 1;
        run_job(2'b11, -1, -1, sd, np, s0, lat);
        check("restart_done", sd, 1);
        c_pre[1] = 0;

        for (int j = 0; j < 8; j++) begin
            c_len[0] = $urandom_range(0, 20);
            c_len[1] = $urandom_range(0, 20);
            c_pre[1] = 1'($urandom_range(0, 1));
            run_job(N'($urandom), ($urandom_range(0, 3) == 0) ?
                    int'($urandom_range(0, 15)) : -1, -1, sd, np, s0, lat);
            c_pre[1] = 0;
        end

        // asynchronous reset while client 0 runs
        c_len[0] = 100; job_mask = 2'b01; req_start = 1'b1;
        repeat (12) step();
        #2 rst = 1'b1;
        #1 check_zero("arst");
        @(negedge clk);
        check_zero("arst_hold");
        reset_clients();
        model_reset();
        req_start = 1'b0;
        rst = 1'b0;
        drive_adv();

        c_len[0] = 6; c_len[1] = 4;
        run_job(2'b11, -1, -1, sd, np, s0, lat);
        check("post_rst_done", sd, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
